// File: rtl/onchip_copier_pkg.sv
// ---------------------------------------------------------------------------
// onchip_copier_pkg
//   Shared definitions for the on-chip memory copier:
//   - copier FSM state encoding
//   - default values for the copier parameters
//   - byteenable all-ones constant (wide; users truncate to their width)
// ---------------------------------------------------------------------------
package onchip_copier_pkg;

  // Default parameter values (4096 x 32 on-chip memory).
  localparam int unsigned ADDR_W_DEF       = 12;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned LEN_W_DEF        = 13;
  localparam int unsigned READ_LATENCY_DEF = 1;

  // Width of the read-latency down counter (latency is 1..4).
  localparam int unsigned LAT_W = 3;

  // All-ones byteenable; wide enough for any supported DATA_W, sliced by users.
  localparam int unsigned          BE_MAX_W    = 128;
  localparam logic [BE_MAX_W-1:0]  BE_ALL_ONES = {BE_MAX_W{1'b1}};

  // Copier FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage : onchip_copier_pkg

// File: rtl/onchip_memory_copier_if.sv
// ---------------------------------------------------------------------------
// onchip_memory_copier_if
//   Avalon-MM bus between the copier (master) and the on-chip memory s1
//   port (slave).
//   address     : word address             (master -> slave)
//   chipselect  : high with read or write  (master -> slave)
//   read/write  : command strobes          (master -> slave)
//   byteenable  : byte lanes for writes    (master -> slave)
//   writedata   : write data               (master -> slave)
//   readdata    : read data                (slave  -> master)
//   waitrequest : command stall            (slave  -> master)
// ---------------------------------------------------------------------------
interface onchip_memory_copier_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, waitrequest
  );

endinterface : onchip_memory_copier_if

// File: rtl/onchip_memory_copier.sv
// ---------------------------------------------------------------------------
// onchip_memory_copier
//   Avalon-MM initiator copying a block of words inside the on-chip memory,
//   one read followed by one write per word, in ascending address order.
//
//   Ports:
//     clk        : clock, all logic on rising edge
//     reset      : synchronous active-high reset
//     start      : one-cycle copy request, sampled only in IDLE
//     src_addr   : first source word address
//     dst_addr   : first destination word address
//     len        : number of words to copy (0 completes immediately)
//     busy       : high while a copy is in progress
//     done       : one-cycle pulse after the last write is accepted
//     checksum   : (only with ONCHIP_COPIER_CHECKSUM_EN) modulo-2^DATA_W sum
//                  of the words written by the current/last copy
//     avm        : Avalon-MM master port (onchip_memory_copier_if.master)
//
//   Optional feature macro: ONCHIP_COPIER_CHECKSUM_EN
//
//   All outputs are registered: next-cycle values are decoded from the next
//   state, so nothing combinational reaches the pins from waitrequest.
// ---------------------------------------------------------------------------
module onchip_memory_copier
  import onchip_copier_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LEN_W        = LEN_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
`ifdef ONCHIP_COPIER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  onchip_memory_copier_if.master avm
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [BE_W-1:0]   BE_ONES   = BE_W'(BE_ALL_ONES);
  localparam logic [BE_W-1:0]   BE_ZERO   = {BE_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ZERO  = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY);

  // Control state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Registered outputs
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [BE_W-1:0]   be_q, be_d;

`ifdef ONCHIP_COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    data_d    = data_q;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ONCHIP_COPIER_CHECKSUM_EN
          sum_d = DATA_ZERO;
`endif
          if (len != LEN_ZERO) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RD: begin
        if (!avm.waitrequest) begin
          lat_d   = LAT_INIT;
          state_d = RD_WAIT;
        end else begin
          state_d = RD;
        end
      end

      RD_WAIT: begin
        // Counter == 1 marks the cycle in which readdata is valid.
        if (lat_q <= LAT_ONE) begin
          data_d  = avm.readdata;
          lat_d   = LAT_ZERO;
          state_d = WR;
        end else begin
          lat_d   = lat_q - LAT_ONE;
          state_d = RD_WAIT;
        end
      end

      WR: begin
        if (!avm.waitrequest) begin
          src_d = src_q + ADDR_ONE;   // wraps modulo 2^ADDR_W
          dst_d = dst_q + ADDR_ONE;
          rem_d = rem_q - LEN_ONE;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (rem_q == LEN_ONE) begin
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = WR;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs for the next cycle follow the next state; during a stall the
    // address sources are unchanged, so the command is held stable.
    busy_d    = 1'b0;
    done_d    = 1'b0;
    address_d = ADDR_ZERO;
    cs_d      = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    be_d      = BE_ZERO;

    case (state_d)
      RD: begin
        busy_d    = 1'b1;
        cs_d      = 1'b1;
        rd_d      = 1'b1;
        address_d = src_d;
      end
      RD_WAIT: begin
        busy_d    = 1'b1;
      end
      WR: begin
        busy_d    = 1'b1;
        cs_d      = 1'b1;
        wr_d      = 1'b1;
        be_d      = BE_ONES;
        address_d = dst_d;
      end
      DONE: begin
        done_d    = 1'b1;
      end
      default: begin
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= ADDR_ZERO;
      dst_q     <= ADDR_ZERO;
      rem_q     <= LEN_ZERO;
      lat_q     <= LAT_ZERO;
      data_q    <= DATA_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      address_q <= ADDR_ZERO;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= BE_ZERO;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
      sum_q     <= DATA_ZERO;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      lat_q     <= lat_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm.address    = address_q;
  assign avm.chipselect = cs_q;
  assign avm.read       = rd_q;
  assign avm.write      = wr_q;
  assign avm.byteenable = be_q;
  // The capture register is the write data; it resets to zero.
  assign avm.writedata  = data_q;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
  assign checksum       = sum_q;
`endif

endmodule : onchip_memory_copier

// File: tb/tb_onchip_memory_copier.sv
// ---------------------------------------------------------------------------
// tb_onchip_memory_copier
//   Self-checking bench: 4096-word memory model with read latency 1, a
//   reference copy model (sequential array copy), table-driven copies,
//   random copies, and hand-written stall / mid-copy reset sequences.
//   Honours ONCHIP_COPIER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_onchip_memory_copier;
  import onchip_copier_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
`ifdef ONCHIP_COPIER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  onchip_memory_copier_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

  onchip_memory_copier #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .avm      (avm.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model (slave side) ----------------
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          fill_req = 1'b0;
  int            fill_seed = 0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  logic [DW-1:0] rdata_q = '0;
  logic          wait_s = 1'b0;

  function automatic logic [DW-1:0] fill_val(input int idx, input int seed);
    if (seed == 0) return 32'(idx) + 32'h100;
    else return (32'(idx) * 32'h9E3779B1) ^ 32'(seed);
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= fill_val(i, fill_seed);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (avm.chipselect && avm.write && !avm.waitrequest) begin
      mem[avm.address] <= avm.writedata;
    end
    if (avm.chipselect && avm.read && !avm.waitrequest) rdata_q <= mem[avm.address];
  end

  assign avm.readdata    = rdata_q;
  assign avm.waitrequest = wait_s;

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_fill(input int seed);
    @(negedge clk);
    fill_seed = seed;
    fill_req  = 1'b1;
    @(negedge clk);
    fill_req  = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = fill_val(i, seed);
  endtask

  task automatic do_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // One copy with no stalls; reference model = sequential word copy.
  task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int exp_done, input int exp_rd,
                          input bit spur);
    logic [AW-1:0] exp_ra[$];
    logic [AW-1:0] exp_wa[$];
    logic [AW-1:0] ra[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] exp_sum = '0;
    int got_done = -1;
    int busy_cnt = 0;
    int be_bad = 0;
    int am = 0;
    logic busy_at_done = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] sa = s + AW'(i);
      logic [AW-1:0] da = d + AW'(i);
      exp_ra.push_back(sa);
      exp_wa.push_back(da);
      ref_mem[da] = ref_mem[sa];
      exp_sum += ref_mem[da];
    end
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    for (int k = 1; k <= exp_done + 20 && got_done < 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (avm.chipselect && avm.read && !avm.waitrequest) ra.push_back(avm.address);
      if (avm.chipselect && avm.write && !avm.waitrequest) begin
        wa.push_back(avm.address);
        if (avm.byteenable != 4'hF) be_bad++;
      end
      if (!avm.write && avm.byteenable != 4'h0) be_bad++;
      if (done) begin got_done = k; busy_at_done = busy; end
      // A start while busy must be ignored.
      if (spur && k == 2) begin
        start = 1'b1; src_addr = ~s; dst_addr = s; len = 13'd3;
      end else begin
        start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = LW'($urandom);
      end
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(got_done), 32'(exp_done));
    check({tag, " busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
    check({tag, " reads"}, 32'(ra.size()), 32'(exp_rd));
    check({tag, " writes"}, 32'(wa.size()), 32'(exp_rd));
    for (int i = 0; i < int'(n); i++) begin
      if (i >= ra.size() || ra[i] !== exp_ra[i]) am++;
      if (i >= wa.size() || wa[i] !== exp_wa[i]) am++;
    end
    check({tag, " addr_seq"}, 32'(am), 32'd0);
    check({tag, " byteenable"}, 32'(be_bad), 32'd0);
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    check({tag, " checksum"}, checksum, exp_sum);
`endif
    @(negedge clk);
    check({tag, " done_pulse_1cyc"}, {31'd0, done}, 32'd0);
    mem_compare({tag, " memory"});
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    int            seed;
    int            exp_done;
    int            exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{12'h000, 12'h100, 13'd8, 0,     25, 8};  // basic block
    vecs[1] = '{12'h005, 12'h200, 13'd0, 7,     1,  0};  // len = 0
    vecs[2] = '{12'hFFE, 12'h010, 13'd4, 11,    13, 4};  // source wrap
    vecs[3] = '{12'h020, 12'h021, 13'd6, 23,    19, 6};  // dst=src+1 replicate
    vecs[4] = '{12'h040, 12'h03E, 13'd5, 31,    16, 5};  // backward overlap
    vecs[5] = '{12'hFFD, 12'hFFF, 13'd3, 47,    10, 3};  // both wrap

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset outputs",
          {16'd0, done, avm.read, avm.write, avm.chipselect, avm.address},
          32'd0);
    check("reset be_wdata", {28'd0, avm.byteenable} | avm.writedata, 32'd0);
`ifdef ONCHIP_COPIER_CHECKSUM_EN
    check("reset checksum", checksum, 32'd0);
`endif
    reset = 1'b0;

    // ---- table-driven copies ----
    foreach (vecs[v]) begin
      do_fill(vecs[v].seed);
      run_copy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
               vecs[v].exp_done, vecs[v].exp_rd, vecs[v].len != 0);
    end

    // ---- randomized copies against the model ----
    do_fill(99);
    for (int r = 0; r < 10; r++) begin
      logic [AW-1:0] s = AW'($urandom_range(0, 4095));
      logic [AW-1:0] d = AW'($urandom_range(0, 4095));
      int n = $urandom_range(1, 24);
      run_copy($sformatf("rand%0d", r), s, d, LW'(n), 3 * n + 1, n, 1'b1);
    end

    // ---- stall sequence: 3 read stalls, 2 write stalls, len = 1 ----
    begin
      logic [DW-1:0] expv;
      int got_done = -1;
      int stable_bad = 0;
      do_fill(5);
      expv = ref_mem[12'h123];
      ref_mem[12'h456] = expv;
      @(negedge clk);
      start = 1'b1; src_addr = 12'h123; dst_addr = 12'h456; len = 13'd1;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (k >= 1 && k <= 4 &&
            !(avm.read && avm.chipselect && !avm.write && avm.address == 12'h123))
          stable_bad++;
        if (k >= 6 && k <= 8 &&
            !(avm.write && avm.chipselect && !avm.read && avm.address == 12'h456 &&
              avm.writedata == expv && avm.byteenable == 4'hF))
          stable_bad++;
        if (done && got_done < 0) got_done = k;
        wait_s = (k == 1 || k == 2 || k == 3 || k == 6 || k == 7);
      end
      wait_s = 1'b0;
      check("stall done_cycle", 32'(got_done), 32'd9);
      check("stall cmd_stable", 32'(stable_bad), 32'd0);
      mem_compare("stall memory");
    end

    // ---- reset in RD_WAIT of the second word, len = 4 ----
    begin
      do_fill(77);
      ref_mem[12'h310] = ref_mem[12'h300];
      @(negedge clk);
      start = 1'b1; src_addr = 12'h300; dst_addr = 12'h310; len = 13'd4;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        start = 1'b0;
      end
      check("rst pre_state", {29'd0, busy, avm.read, avm.write}, 32'd4);
      reset = 1'b1;
      @(negedge clk);
      check("rst outputs",
            {15'd0, busy, done, avm.read, avm.write, avm.chipselect, avm.address},
            32'd0);
      check("rst be_wdata", {28'd0, avm.byteenable} | avm.writedata, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst stays_idle", {29'd0, busy, avm.read, avm.write}, 32'd0);
      mem_compare("rst memory");
      run_copy("rst_recopy", 12'h300, 12'h310, 13'd4, 13, 4, 1'b0);
    end

`ifdef ONCHIP_COPIER_CHECKSUM_EN
    // ---- checksum with carry wrap ----
    do_poke(12'h500, 32'hFFFFFFFF);
    do_poke(12'h501, 32'h00000002);
    do_poke(12'h502, 32'h00000005);
    run_copy("csum", 12'h500, 12'h600, 13'd3, 10, 3, 1'b0);
    repeat (3) @(negedge clk);
    check("csum value", checksum, 32'h00000006);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_onchip_memory_copier
